tx_frame_scheduler: RTL and testbench
=====================================

Name: tx_frame_scheduler

Overview:
- Shares the single serial transmit frame slot between NCH ADC-channel requesters using round-robin arbitration.
- Arbitrates between frames and latches the winner's sample tagged with its channel id. Presents the word to the transmit shift register on the frame-start strobe from the transmit bit timer.
- Sits between the per-channel ADC capture blocks and the serial transmitter/timer pair.

Parameters:
- NCH, 4, number of requesting channels (2..8)
- DW, 12, sample data width per channel
- IDW, 2, channel-id field width; must satisfy 2**IDW >= NCH
- IDLE_WORD, all ones, payload sent in a frame with no grant

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- st  in  1  frame-start strobe from transmit timer, one clk wide
- req  in  NCH  per-channel request level, held until ack
- din  in  NCH*DW  packed samples; channel k at bits [k*DW +: DW]
- ack  out  NCH  one-clk pulse to the channel whose word was loaded
- tx_data  out  IDW+DW  {id, sample} to shift register; stable from load until next load
- tx_load  out  1  one-clk pulse, same cycle as st, when a granted word is loaded
- tx_idle  out  1  one-clk pulse, same cycle as st, when an idle frame is loaded
- frame_cnt  out  16  count of tx_load pulses, wraps 0xFFFF->0

Behaviour:
- Reset:
  - state=WAIT, rr pointer=0, ack=0, tx_load=0, tx_idle=0, frame_cnt=0.
  - tx_data={all ones id, IDLE_WORD}.
  - Reset mid-ARMED discards the latched grant; no ack is issued.
- All outputs are registered. Load and ack appear one clk after the st input edge is sampled; tx_load/tx_idle/ack are registered versions of the st-cycle decision.
- WAIT state, with any req bit high and no st that cycle:
  - pick the first set req at or after the pointer, searching upward with wrap NCH-1 -> 0;
  - latch grant g and din[g];
  - go to ARMED.
- WAIT state, st high: always an idle frame. tx_idle=1, tx_data={all ones, IDLE_WORD}. A req rising in the same cycle is not served; arbitration needs one clk.
- ARMED state, st high and req[g] still high:
  - tx_load=1, ack[g]=1, tx_data={g, latched sample};
  - pointer <= (g+1) mod NCH; frame_cnt++;
  - go to WAIT.
- ARMED state, req[g] low (requester withdrew): return to WAIT with no ack and the pointer unchanged. If st coincides, that frame is idle (tx_idle=1).
- ARMED state, st low: hold. The latched sample is not refreshed.
- Never more than one ack bit set. ack and tx_idle are mutually exclusive.
- No st for a long time: grant is held indefinitely in ARMED; no timeout.
- A channel acked in frame n can win frame n+1 only if no other channel requests.

Optional Feature:
- TX_PARITY_EN defined:
  - tx_data widens to IDW+DW+1;
  - LSB is the even-parity bit over {id, sample};
  - idle frame parity is computed the same way.
- Not defined: width is IDW+DW with no parity bit; all other behaviour is identical.

Decomposition:
- Shared package/include holds:
  - NCH, DW, IDW, IDLE_WORD defaults;
  - WAIT/ARMED state encoding;
  - the tx_data width macro, which depends on TX_PARITY_EN.
- One natural sub-module, rr_arbiter: combinational.
  - Inputs: req, pointer.
  - Outputs: grant index and a valid flag.
  - Reused by other shared-resource blocks.

Test Plan:
- Reset, then st with req=0 -> tx_idle=1, tx_load=0, tx_data=0x3FFF (IDW=2, DW=12), frame_cnt=0.
- req=4'b1111 held, din ch0..3 = 0x111/0x222/0x333/0x444, 4 st pulses -> tx_data 0x0111, 0x1222, 0x2333, 0x3444. ack order 1,2,4,8. frame_cnt=4.
- req=4'b0100 raised in the same cycle as st -> that frame is idle. Next st -> tx_data=0x2xxx and ack=4'b0100.
- Channel 1 armed, req[1] dropped before st -> no ack[1]. The following st is idle. Pointer still selects ch1 when req[1] is reasserted.
- frame_cnt preset by 65535 loads -> the next load wraps it to 0.
- rst asserted while ARMED, released, then st -> idle frame; no ack pulse at any point.

Source files
------------

// File: rtl/tx_frame_scheduler_pkg.sv
// Shared definitions for tx_frame_scheduler: default sizes, FSM encoding, tx word width.
// Optional: define TX_PARITY_EN to append an even-parity LSB to every tx word.
`ifndef TX_FRAME_SCHEDULER_PKG_SV
`define TX_FRAME_SCHEDULER_PKG_SV

package tx_frame_scheduler_pkg;
  localparam int NCH_DEF = 4;
  localparam int DW_DEF  = 12;
  localparam int IDW_DEF = 2;
  localparam logic [DW_DEF-1:0] IDLE_WORD_DEF = '1;

  typedef enum logic {
    ST_WAIT  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

`ifdef TX_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
endpackage

`define TFS_TXW(idw, dw) ((idw) + (dw) + tx_frame_scheduler_pkg::PAR_W)

`endif

// File: rtl/tx_frame_scheduler_if.sv
// Bus between the ADC capture blocks, the scheduler and the serial transmitter.
// tx_data width grows by one bit when TX_PARITY_EN is defined.
interface tx_frame_scheduler_if #(
  parameter int NCH = tx_frame_scheduler_pkg::NCH_DEF,
  parameter int DW  = tx_frame_scheduler_pkg::DW_DEF,
  parameter int IDW = tx_frame_scheduler_pkg::IDW_DEF
);
  localparam int TXW = `TFS_TXW(IDW, DW);

  logic              st;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] din;
  logic [NCH-1:0]    ack;
  logic [TXW-1:0]    tx_data;
  logic              tx_load;
  logic              tx_idle;
  logic [15:0]       frame_cnt;

  modport master (
    input  st, req, din,
    output ack, tx_data, tx_load, tx_idle, frame_cnt
  );

  modport slave (
    output st, req, din,
    input  ack, tx_data, tx_load, tx_idle, frame_cnt
  );
endinterface

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req at or above ptr, wrapping NCH-1 -> 0.
module rr_arbiter
  import tx_frame_scheduler_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int IDW = IDW_DEF
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] grant,
  output logic           valid
);
  logic [IDW-1:0] cand [NCH];

  // cand[k] is the channel k places after the pointer
  for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
    logic [IDW:0] sum;
    assign sum = {1'b0, ptr} + (IDW+1)'(gi);
    assign cand[gi] = (sum >= (IDW+1)'(NCH)) ? IDW'(sum - (IDW+1)'(NCH)) : sum[IDW-1:0];
  end

  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        grant = cand[i];
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler sharing one serial tx frame slot between NCH ADC channels.
// Optional: TX_PARITY_EN appends an even-parity LSB to tx_data.
module tx_frame_scheduler
  import tx_frame_scheduler_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF,
  parameter int IDW = IDW_DEF,
  parameter logic [DW-1:0] IDLE_WORD = '1
) (
  input logic clk,
  input logic rst,
  tx_frame_scheduler_if.master bus
);
  localparam int TXW = `TFS_TXW(IDW, DW);

  function automatic logic [TXW-1:0] make_word(input logic [IDW-1:0] id, input logic [DW-1:0] sample);
`ifdef TX_PARITY_EN
    return {id, sample, ^{id, sample}};
`else
    return {id, sample};
`endif
  endfunction

  localparam logic [TXW-1:0] IDLE_FRAME = make_word({IDW{1'b1}}, IDLE_WORD);

  state_t         state_reg;
  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] grant_reg;
  logic [DW-1:0]  sample_reg;
  logic [NCH-1:0] ack_reg;
  logic           load_reg;
  logic           idle_reg;
  logic [TXW-1:0] data_reg;
  logic [15:0]    frame_cnt_reg;
  logic [15:0]    frame_cnt_next;
  logic           load_now;

  logic [IDW-1:0] arb_grant;
  logic           arb_valid;
  logic [DW-1:0]  sample_ch [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
    assign sample_ch[gi] = bus.din[gi*DW +: DW];
  end

  rr_arbiter #(
    .NCH (NCH),
    .IDW (IDW)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  assign load_now       = (state_reg == ST_ARMED) && bus.st && bus.req[grant_reg];
  assign frame_cnt_next = frame_cnt_reg + {15'd0, load_now};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_WAIT;
      ptr_reg    <= '0;
      grant_reg  <= '0;
      sample_reg <= '0;
      ack_reg    <= '0;
      load_reg   <= 1'b0;
      idle_reg   <= 1'b0;
      data_reg   <= IDLE_FRAME;
    end else begin
      ack_reg  <= '0;
      load_reg <= 1'b0;
      idle_reg <= 1'b0;
      case (state_reg)
        ST_WAIT: begin
          // A frame start in WAIT is always idle; arbitration takes its own cycle
          if (bus.st) begin
            idle_reg <= 1'b1;
            data_reg <= IDLE_FRAME;
          end else if (arb_valid) begin
            grant_reg  <= arb_grant;
            sample_reg <= sample_ch[arb_grant];
            state_reg  <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (!bus.req[grant_reg]) begin
            state_reg <= ST_WAIT;
            if (bus.st) begin
              idle_reg <= 1'b1;
              data_reg <= IDLE_FRAME;
            end
          end else if (bus.st) begin
            load_reg  <= 1'b1;
            ack_reg   <= NCH'(1) << grant_reg;
            data_reg  <= make_word(grant_reg, sample_reg);
            ptr_reg   <= (grant_reg == IDW'(NCH - 1)) ? '0 : grant_reg + 1'b1;
            state_reg <= ST_WAIT;
          end
        end
        default: state_reg <= ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) frame_cnt_reg <= '0;
    else     frame_cnt_reg <= frame_cnt_next;
  end

  assign bus.ack       = ack_reg;
  assign bus.tx_load   = load_reg;
  assign bus.tx_idle   = idle_reg;
  assign bus.tx_data   = data_reg;
  assign bus.frame_cnt = frame_cnt_reg;
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Bench for tx_frame_scheduler: directed plan checks plus randomized traffic against a frame-level model.
module tb_tx_frame_scheduler;
  localparam int NCH = 4;
  localparam int DW  = 12;
  localparam int IDW = 2;
`ifdef TX_PARITY_EN
  localparam int TXW = IDW + DW + 1;
`else
  localparam int TXW = IDW + DW;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_frame_scheduler_if #(.NCH(NCH), .DW(DW), .IDW(IDW)) ifc ();

  tx_frame_scheduler #(.NCH(NCH), .DW(DW), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Hand-written payload literals gain a parity LSB in the parity build
  function automatic logic [TXW-1:0] lit(input logic [IDW+DW-1:0] v);
`ifdef TX_PARITY_EN
    return {v, ^v};
`else
    return v;
`endif
  endfunction

  function automatic logic [TXW-1:0] mk(input int id, input logic [DW-1:0] s);
    logic [IDW+DW-1:0] v;
    v = {IDW'(id), s};
    return lit(v);
  endfunction

  function automatic int first_from(input logic [NCH-1:0] r, input int p);
    for (int i = 0; i < NCH; i++) begin
      if (r[(p + i) % NCH]) return (p + i) % NCH;
    end
    return -1;
  endfunction

  // Frame-level model: one pending grant, a pointer, a frame counter
  bit             started = 0;
  bit             m_armed;
  int             m_g, m_ptr, w;
  logic [DW-1:0]  m_samp;
  logic [NCH-1:0] m_ack;
  logic           m_load, m_idle;
  logic [TXW-1:0] m_data;
  logic [15:0]    m_cnt;
  logic [TXW-1:0] idle_full;

  initial idle_full = lit('1);

  always @(posedge clk) begin
    started = 1;
    m_ack   = '0;
    m_load  = 1'b0;
    m_idle  = 1'b0;
    if (rst) begin
      m_armed = 0;
      m_ptr   = 0;
      m_cnt   = '0;
      m_data  = idle_full;
    end else if (!m_armed) begin
      if (ifc.st) begin
        m_idle = 1'b1;
        m_data = idle_full;
      end else begin
        w = first_from(ifc.req, m_ptr);
        if (w >= 0) begin
          m_armed = 1;
          m_g     = w;
          m_samp  = ifc.din[w*DW +: DW];
        end
      end
    end else if (!ifc.req[m_g]) begin
      m_armed = 0;
      if (ifc.st) begin
        m_idle = 1'b1;
        m_data = idle_full;
      end
    end else if (ifc.st) begin
      m_load     = 1'b1;
      m_ack[m_g] = 1'b1;
      m_data     = mk(m_g, m_samp);
      m_ptr      = (m_g + 1) % NCH;
      m_cnt      = m_cnt + 16'd1;
      m_armed    = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ack", 32'(ifc.ack), 32'(m_ack));
      chk("tx_load", 32'(ifc.tx_load), 32'(m_load));
      chk("tx_idle", 32'(ifc.tx_idle), 32'(m_idle));
      chk("tx_data", 32'(ifc.tx_data), 32'(m_data));
      chk("frame_cnt", 32'(ifc.frame_cnt), 32'(m_cnt));
      chk("ack_excl", 32'(($countones(ifc.ack) <= 1) && !((|ifc.ack) && ifc.tx_idle)), 32'd1);
      if (m_load) $display("frame load: ack=%b data=%h cnt=%0d", ifc.ack, ifc.tx_data, ifc.frame_cnt);
      else if (m_idle) $display("frame idle: data=%h cnt=%0d", ifc.tx_data, ifc.frame_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [IDW+DW-1:0] exp4 [4];

  initial begin
    ifc.st  = 1'b0;
    ifc.req = '0;
    ifc.din = '0;
    exp4[0] = 14'h0111;
    exp4[1] = 14'h1222;
    exp4[2] = 14'h2333;
    exp4[3] = 14'h3444;

    // Reset state, then an idle frame
    rst = 1'b1;
    repeat (3) step();
    chk("rst_data", 32'(ifc.tx_data), 32'(lit(14'h3FFF)));
    chk("rst_cnt", 32'(ifc.frame_cnt), 32'd0);
    chk("rst_ack", 32'(ifc.ack), 32'd0);
    rst = 1'b0;
    ifc.st = 1'b1;
    step();
    ifc.st = 1'b0;
    chk("idle0_idle", 32'(ifc.tx_idle), 32'd1);
    chk("idle0_load", 32'(ifc.tx_load), 32'd0);
    chk("idle0_data", 32'(ifc.tx_data), 32'(lit(14'h3FFF)));

    // All four channels requesting: strict rotation
    ifc.din = {12'h444, 12'h333, 12'h222, 12'h111};
    ifc.req = 4'b1111;
    step();
    for (int i = 0; i < 4; i++) begin
      ifc.st = 1'b1;
      step();
      ifc.st = 1'b0;
      chk("rot_data", 32'(ifc.tx_data), 32'(lit(exp4[i])));
      chk("rot_ack", 32'(ifc.ack), 32'(4'b0001 << i));
      step();
    end
    chk("rot_cnt", 32'(ifc.frame_cnt), 32'd4);
    ifc.req = '0;
    repeat (2) step();

    // Request arriving with st is not served in that frame
    ifc.req = 4'b0100;
    ifc.st  = 1'b1;
    step();
    ifc.st = 1'b0;
    chk("late_idle", 32'(ifc.tx_idle), 32'd1);
    chk("late_ack", 32'(ifc.ack), 32'd0);
    step();
    ifc.st = 1'b1;
    step();
    ifc.st = 1'b0;
    chk("late_data", 32'(ifc.tx_data), 32'(lit(14'h2333)));
    chk("late_ack2", 32'(ifc.ack), 32'd4);
    ifc.req = '0;
    step();

    // Move the pointer to 1 via a ch0 load
    ifc.req = 4'b0001;
    step();
    ifc.st = 1'b1;
    step();
    ifc.st  = 1'b0;
    ifc.req = '0;
    chk("ch0_data", 32'(ifc.tx_data), 32'(lit(14'h0111)));
    step();

    // Withdrawal: ch1 armed then drops; pointer must stay at 1
    ifc.req = 4'b0010;
    step();
    ifc.req = '0;
    step();
    ifc.st = 1'b1;
    step();
    ifc.st = 1'b0;
    chk("wd_idle", 32'(ifc.tx_idle), 32'd1);
    chk("wd_ack", 32'(ifc.ack), 32'd0);
    ifc.req = 4'b0110;
    step();
    ifc.st = 1'b1;
    step();
    ifc.st  = 1'b0;
    ifc.req = '0;
    chk("wd_reack", 32'(ifc.ack), 32'd2);
    chk("wd_data", 32'(ifc.tx_data), 32'(lit(14'h1222)));
    chk("wd_cnt", 32'(ifc.frame_cnt), 32'd7);
    step();

    // Counter wrap from a preset near the top
    force dut.frame_cnt_reg = 16'hFFFE;
    m_cnt = 16'hFFFE;
    step();
    release dut.frame_cnt_reg;
    ifc.req = 4'b0001;
    step();
    ifc.st = 1'b1;
    step();
    ifc.st = 1'b0;
    chk("wrap_ffff", 32'(ifc.frame_cnt), 32'hFFFF);
    step();
    ifc.st = 1'b1;
    step();
    ifc.st  = 1'b0;
    ifc.req = '0;
    chk("wrap_zero", 32'(ifc.frame_cnt), 32'd0);
    repeat (2) step();

    // Reset while armed discards the grant
    ifc.req = 4'b0100;
    step();
    rst     = 1'b1;
    ifc.req = '0;
    step();
    rst = 1'b0;
    step();
    ifc.st = 1'b1;
    step();
    ifc.st = 1'b0;
    chk("rstarm_idle", 32'(ifc.tx_idle), 32'd1);
    chk("rstarm_ack", 32'(ifc.ack), 32'd0);
    chk("rstarm_data", 32'(ifc.tx_data), 32'(lit(14'h3FFF)));

    // Randomized traffic: requests held until acked, occasional withdrawal and reset
    for (int n = 0; n < 3000; n++) begin
      step();
      ifc.st = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < NCH; k++) begin
        ifc.din[k*DW +: DW] = DW'($urandom);
        if (m_ack[k]) ifc.req[k] = 1'b0;
        else if (!ifc.req[k] && $urandom_range(0, 2) == 0) ifc.req[k] = 1'b1;
        else if (ifc.req[k] && $urandom_range(0, 15) == 0) ifc.req[k] = 1'b0;
      end
      rst = ($urandom_range(0, 199) == 0);
    end
    ifc.st = 1'b0;
    rst    = 1'b0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
